// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth mantissa multiplier: 24x24 unsigned -> 48-bit product, one digit per cycle.
// Optional BOOTH_EARLY_EXIT_EN: zero operands bypass CALC and complete directly in DONE.
module fp_mul_booth_seq #(
    parameter int unsigned TAG_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [22:0]      frc_X,
    input  logic [22:0]      frc_Y,
    input  logic             hid_X,
    input  logic             hid_Y,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      frc_Z_full,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned MANT_W = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned HI_W   = 27;
    localparam int unsigned LO_W   = 26;
    localparam int unsigned BR_W   = 27;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(12);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [MANT_W-1:0] a_q,       a_d;
    logic [BR_W-1:0]   b_q,       b_d;
    logic [HI_W-1:0]   hi_q,      hi_d;
    logic [LO_W-1:0]   lo_q,      lo_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic [PROD_W-1:0] z_q,       z_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;

    logic [MANT_W-1:0] op_a;
    logic [MANT_W-1:0] op_b;
    logic [HI_W-1:0]   a_x1;
    logic [HI_W-1:0]   a_x2;
    logic [HI_W-1:0]   mult;
    logic [HI_W-1:0]   sum;
    logic              accept;

    assign op_a       = {hid_X, frc_X};
    assign op_b       = {hid_Y, frc_Y};
    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid  = (state_q == S_DONE);
    assign accept     = in_valid && in_ready;
    assign frc_Z_full = z_q;
    assign tag_out    = tag_out_q;

    // Booth digit select on the low three bits of the shifting multiplier.
    always_comb begin
        a_x1 = HI_W'(a_q);
        a_x2 = HI_W'({a_q, 1'b0});
        mult = '0;
        case (b_q[2:0])
            3'b001, 3'b010: mult = a_x1;
            3'b011:         mult = a_x2;
            3'b100:         mult = HI_W'(0) - a_x2;
            3'b101, 3'b110: mult = HI_W'(0) - a_x1;
            default:        mult = '0;
        endcase
        sum = hi_q + mult;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        tag_d     = tag_q;
        z_d       = z_q;
        tag_out_d = tag_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    a_d     = op_a;
                    b_d     = {2'b00, op_b, 1'b0};
                    hi_d    = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    tag_d   = tag_in;
                    state_d = S_CALC;
`ifdef BOOTH_EARLY_EXIT_EN
                    if ((op_a == '0) || (op_b == '0)) begin
                        state_d   = S_DONE;
                        z_d       = '0;
                        tag_out_d = tag_in;
                    end
`endif
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                // Arithmetic shift of {hi, lo} by two after adding the selected multiple.
                hi_d  = {{2{sum[HI_W-1]}}, sum[HI_W-1:2]};
                lo_d  = {sum[1:0], lo_q[LO_W-1:2]};
                b_d   = {2'b00, b_q[BR_W-1:2]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    state_d   = S_DONE;
                    z_d       = PROD_W'({hi_d, lo_d});
                    tag_out_d = tag_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            tag_q     <= '0;
            z_q       <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            tag_q     <= tag_d;
            z_q       <= z_d;
            tag_out_q <= tag_out_d;
        end
    end

endmodule
